// File: rtl/fetch_pair_splitter_pkg.sv
// Shared frontend definitions: instruction/PC widths, buffer state encoding
// and the {pc, instr} entry type written into the instruction FIFO.
package fetch_pair_splitter_pkg;

  localparam int FE_INST_WIDTH = 32;
  localparam int FE_PC_WIDTH   = 32;

  // Number of {pc, instr} entries currently held by the splitter.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  // One FIFO entry; pc occupies the upper bits so the packed value is {pc, instr}.
  typedef struct packed {
    logic [FE_PC_WIDTH-1:0]   pc;
    logic [FE_INST_WIDTH-1:0] instr;
  } fe_entry_t;

  // Packs a program counter and an instruction into one FIFO entry.
  function automatic fe_entry_t pack_entry(input logic [FE_PC_WIDTH-1:0]   pc,
                                           input logic [FE_INST_WIDTH-1:0] instr);
    fe_entry_t e;
    e.pc    = pc;
    e.instr = instr;
    return e;
  endfunction

endpackage

// File: rtl/fetch_pair_splitter.sv
// Splits a two-instruction fetch packet into {pc, instr} entries and writes
// them into a dual-write FIFO, buffering up to two entries while the FIFO
// lacks space. A packet starting on an odd word only carries slot 1.
module fetch_pair_splitter
  import fetch_pair_splitter_pkg::*;
#(
  parameter int FIFO_SIZE       = 32,
  parameter int FIFO_SIZE_WIDTH = 5,
  parameter int INST_WIDTH      = FE_INST_WIDTH,
  parameter int PC_WIDTH        = FE_PC_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pkt_valid_i,
  output logic                           pkt_ready_o,
  input  logic [2*INST_WIDTH-1:0]        pkt_data_i,
  input  logic [PC_WIDTH-1:0]            pkt_pc_i,
  input  logic                           redirect_i,
  input  logic [FIFO_SIZE_WIDTH:0]       fifo_num_i,
  output logic                           wr_first_en_o,
  output logic                           wr_second_en_o,
  output logic [PC_WIDTH+INST_WIDTH-1:0] wdata_first_o,
  output logic [PC_WIDTH+INST_WIDTH-1:0] wdata_second_o
);

  localparam logic [FIFO_SIZE_WIDTH:0] FIFO_CAP = (FIFO_SIZE_WIDTH+1)'(FIFO_SIZE);

  buf_state_e state_q, state_d;
  fe_entry_t  buf0_q, buf0_d;
  fe_entry_t  buf1_q, buf1_d;

  logic [FIFO_SIZE_WIDTH:0] free_slots;
  logic [1:0]               buf_count;
  logic [1:0]               n_write;
  logic                     active;
  logic                     accept;

  // Work out how many buffered entries the FIFO can take this cycle.
  always_comb begin
    free_slots = '0;
    buf_count  = 2'd0;
    n_write    = 2'd0;
    if (fifo_num_i < FIFO_CAP) begin
      free_slots = FIFO_CAP - fifo_num_i;
    end
    case (state_q)
      BUF_ONE: buf_count = 2'd1;
      BUF_TWO: buf_count = 2'd2;
      default: buf_count = 2'd0;
    endcase
    if (free_slots < (FIFO_SIZE_WIDTH+1)'(buf_count)) begin
      n_write = free_slots[1:0];
    end else begin
      n_write = buf_count;
    end
  end

  assign active         = rst && !redirect_i;
  assign wr_first_en_o  = active && (n_write != 2'd0);
  assign wr_second_en_o = active && (n_write == 2'd2);
  assign pkt_ready_o    = active && (n_write == buf_count);
  assign accept         = pkt_valid_i && pkt_ready_o;
  assign wdata_first_o  = buf0_q;
  assign wdata_second_o = buf1_q;

  // Next buffer contents: flush, load a new packet, shift after a partial drain, or hold.
  always_comb begin
    state_d = state_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    if (redirect_i) begin
      state_d = BUF_EMPTY;
    end else if (accept) begin
      if (pkt_pc_i[2] == 1'b0) begin
        buf0_d  = pack_entry(pkt_pc_i, pkt_data_i[INST_WIDTH-1:0]);
        buf1_d  = pack_entry(pkt_pc_i + PC_WIDTH'(4), pkt_data_i[2*INST_WIDTH-1:INST_WIDTH]);
        state_d = BUF_TWO;
      end else begin
        buf0_d  = pack_entry(pkt_pc_i, pkt_data_i[2*INST_WIDTH-1:INST_WIDTH]);
        state_d = BUF_ONE;
      end
    end else if ((state_q == BUF_TWO) && (n_write == 2'd1)) begin
      buf0_d  = buf1_q;
      state_d = BUF_ONE;
    end else if (n_write == buf_count) begin
      state_d = BUF_EMPTY;
    end
  end

  // Register buffer state and contents, clearing everything while reset is held low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= BUF_EMPTY;
      buf0_q  <= '0;
      buf1_q  <= '0;
    end else begin
      state_q <= state_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
    end
  end

endmodule

// File: doc/fetch_pair_splitter.md
FETCH_PAIR_SPLITTER -- requirements
Module: fetch_pair_splitter

Interface
REQ-001 Parameter FIFO_SIZE, default 32, depth of the downstream dual-write/dual-read instruction FIFO.
REQ-002 Parameter FIFO_SIZE_WIDTH, default 5, log2(FIFO_SIZE).
REQ-003 Parameter INST_WIDTH, default 32, width of one instruction.
REQ-004 Parameter PC_WIDTH, default 32, width of the program counter.
REQ-005 clk  input  1  single clock, all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-low reset: state clears on a rising clk edge while rst==0.
REQ-007 pkt_valid_i  input  1  fetch packet valid.
REQ-008 pkt_ready_o  output  1  block accepts the fetch packet this cycle.
REQ-009 pkt_data_i  input  2*INST_WIDTH  packet; [31:0] is slot 0 (lower address), [63:32] is slot 1.
REQ-010 pkt_pc_i  input  PC_WIDTH  packet start PC; bits [1:0] are always 0.
REQ-011 redirect_i  input  1  pipeline flush; discard all buffered instructions.
REQ-012 fifo_num_i  input  FIFO_SIZE_WIDTH+1  current occupancy reported by the FIFO.
REQ-013 wr_first_en_o, wr_second_en_o  output  1 each  FIFO write enables.
REQ-014 wdata_first_o, wdata_second_o  output  PC_WIDTH+INST_WIDTH each  {pc, instr} entries.

Function
REQ-015 Slot validity on accept: pkt_pc_i[2]==0 -> both slots valid, PCs pkt_pc_i and pkt_pc_i+4; pkt_pc_i[2]==1 -> only slot 1 valid, PC pkt_pc_i.
REQ-016 Internal buffer holds up to two {pc, instr} entries; state machine with states EMPTY (0 entries), ONE (1 entry), TWO (2 entries).
REQ-017 free = FIFO_SIZE - fifo_num_i, computed at FIFO_SIZE_WIDTH+1 bits; free never exceeds FIFO_SIZE.
REQ-018 Entries written this cycle: n = min(buffer count, free, 2), combinational from current state and fifo_num_i.
REQ-019 n==2 -> wr_first_en_o=wr_second_en_o=1, oldest entry on wdata_first_o, next entry on wdata_second_o.
REQ-020 n==1 -> wr_first_en_o=1, wr_second_en_o=0, oldest entry on wdata_first_o; wr_second_en_o is never asserted alone.
REQ-021 n==0 -> both enables 0; wdata outputs are don't-care but hold the buffer contents.
REQ-022 pkt_ready_o = rst==1 and redirect_i==0 and (state==EMPTY or n equals buffer count), i.e. the buffer drains fully this cycle.
REQ-023 Accept when pkt_valid_i and pkt_ready_o: next state is ONE or TWO per REQ-015, with the new entries loaded in order, slot 0 first.
REQ-024 Partial drain: TWO with n==1 -> ONE, remaining entry shifted to the oldest position; no packet accepted.
REQ-025 No accept and full drain -> EMPTY; no drain, no accept -> state and contents unchanged.
REQ-026 Zero-bubble throughput: one packet per cycle is accepted while free >= 2 each cycle.
REQ-027 redirect_i==1 -> both write enables 0 that cycle, pkt_ready_o=0, next state EMPTY; redirect overrides all other events.
REQ-028 Entry order into the FIFO equals program order; no entry is duplicated or dropped, except on redirect.
REQ-029 Latency: packet accepted at cycle t -> first FIFO write at the earliest cycle t+1.

Reset
REQ-030 While rst==0 at a clk edge: state<=EMPTY and buffer contents<=0.
REQ-031 During reset cycles, pkt_ready_o=0 and wr_first_en_o=wr_second_en_o=0.
REQ-032 Reset mid-operation discards buffered entries, identical to redirect.

Structure
REQ-033 INST_WIDTH, PC_WIDTH, the {pc, instr} entry type and the state encoding are defined in the shared frontend package.
REQ-034 The block is a single module with no sub-modules; the {pc, instr} packing helper lives in the package.

Verification
REQ-035 Aligned packet: pc=0x1000, data={0x00B00093,0x00A00013}, fifo_num_i=0 -> next cycle both enables 1, wdata_first={0x1000,0x00A00013}, wdata_second={0x1004,0x00B00093}.
REQ-036 Misaligned packet: pc=0x2004, fifo_num_i=0 -> next cycle wr_first_en_o only, wdata_first={0x2004, data[63:32]}.
REQ-037 Near-full: buffer TWO, fifo_num_i=31 -> one write, pkt_ready_o=0; next cycle fifo_num_i=31 -> second entry written, pkt_ready_o=1.
REQ-038 Full: fifo_num_i=32 for 5 cycles -> no writes, pkt_ready_o=0, buffer unchanged; fifo_num_i=30 -> both entries written.
REQ-039 Redirect with TWO buffered and pkt_valid_i=1 -> no writes, no accept, state EMPTY next cycle.
REQ-040 Back-to-back: 8 aligned packets, fifo_num_i<=30 throughout -> 16 entries written in 8 consecutive cycles in PC order.
